tt_stim_sequencer: RTL and testbench
====================================

// Module: tt_stim_sequencer
// PURPOSE
//  Upstream stimulus stage for the 3-input NAND/OR gate circuit: D = ~(A&B) | C, E = A&B.
//  On start, drives A,B,C through all 8 vectors 000..111 in ascending order.
//  Each vector is held for DWELL_CYCLES clocks. The circuit's D,E are sampled once per vector.
//  Replaces the hand-written #10 stimulus loop with a synthesisable, self-timed sequencer.
// PARAMETERS
//  DWELL_CYCLES   10  clocks each vector is held; legal range 2..255
//  SAMPLE_OFFSET   8  dwell count at which D/E are sampled; must be < DWELL_CYCLES
//  ERR_W           4  width of err_cnt; saturates at 2**ERR_W-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous, active-low reset
//  start      in   1      level; accepted only in IDLE
//  a,b,c      out  1 ea   stimulus to the gate circuit; {a,b,c} = vec_idx
//  d_in,e_in  in   1 ea   responses from the gate circuit
//  vec_idx    out  3      index of the current vector
//  busy       out  1      high in RUN
//  done       out  1      one-cycle pulse after the last vector
//  err_cnt    out  ERR_W  mismatch count for the last run
//  err_flag   out  1      err_cnt != 0
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; a=b=c=0; vec_idx=0; dwell=0; busy=0; done=0; err_cnt=0.
//   A reset mid-run aborts the run immediately; no done pulse is issued.
//  FSM IDLE->RUN->DONE->IDLE:
//   IDLE: when start=1 at a posedge, enter RUN and clear vec_idx, dwell and err_cnt.
//   RUN: busy=1; dwell counts 0..DWELL_CYCLES-1.
//    At dwell==DWELL_CYCLES-1: if vec_idx==7, go to DONE; else vec_idx+1 and dwell=0.
//   DONE: done=1 for exactly one cycle; then IDLE. a,b,c hold 111 until the next start.
//  Check: at dwell==SAMPLE_OFFSET, compute exp_e=a&b and exp_d=~(a&b)|c.
//   A mismatch on D or E (or both) counts as one error and increments err_cnt (saturating).
//  Timing: first vector is driven the cycle after start is accepted.
//   Run length = 8*DWELL_CYCLES cycles; done is asserted the next cycle.
//  start in RUN or DONE: ignored, never queued. start held high across DONE: a new run begins from IDLE.
//  err_cnt/err_flag hold their value after done until the next accepted start or reset.
//  X/Z on d_in/e_in at the sample point counts as a mismatch.
// CONFIGURATION
//  `FIRST_FAIL_CAPTURE_EN defined:
//   adds output first_fail (3 bits) and first_fail_vld (1 bit).
//   On the first mismatch of a run, latches vec_idx and sets vld.
//   Both clear on reset or on an accepted start.
//  Not defined: those ports are absent; no other behaviour changes.
// STRUCTURE
//  tt_seq_defs.vh: state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2), N_VEC=8, and the
//   expected-response function exp_de(a,b,c) returning {d,e}.
//  Sub-module tt_dwell_timer: dwell counter with clear/enable, outputs last and sample strobes.
//  Top level holds the FSM, vector counter and checker.
// TESTING
//  1. Correct circuit attached, DWELL=10, start pulsed at t0:
//     vectors 000..111 on 10-cycle boundaries; done at t0+81; err_cnt=0, err_flag=0.
//  2. d_in forced 0: 7 mismatches (every vector except 110); err_cnt=7;
//     with the macro, first_fail=0 and first_fail_vld=1.
//  3. e_in forced 1: 6 mismatches (all except 110 and 111); err_cnt=6, err_flag=1.
//  4. rst_n=0 during vec_idx=4: next cycle a=b=c=0, busy=0, err_cnt=0, no done pulse.
//  5. start re-pulsed during RUN and during DONE: no restart, run length unchanged, exactly one done pulse.
//  6. ERR_W=2 with d_in forced 0: err_cnt saturates at 3.

Source files
------------

// File: rtl/tt_stim_sequencer_pkg.sv
// Shared definitions for the gate-circuit stimulus sequencer: FSM states,
// vector count and the expected response of the NAND/OR circuit.
package tt_stim_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int unsigned N_VEC    = 8;
    localparam logic [2:0]  LAST_VEC = 3'(N_VEC - 1);
    localparam int unsigned DWELL_W  = 8;

    // Returns {d, e} for D = ~(A&B) | C, E = A&B
    function automatic logic [1:0] exp_de(input logic a, input logic b, input logic c);
        logic e;
        e = a & b;
        return {(~e) | c, e};
    endfunction

endpackage

// File: rtl/tt_stim_sequencer_dwell_timer.sv
// Dwell counter for the stimulus sequencer: clear/enable control with
// strobes for the last dwell cycle and the response sample point.
module tt_dwell_timer
    import tt_stim_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES  = 10,
    parameter int unsigned SAMPLE_OFFSET = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o,
    output logic sample_o
);

    logic [DWELL_W-1:0] dwell_q, dwell_d;

    always_comb begin
        dwell_d = dwell_q;
        if (clr_i) begin
            dwell_d = '0;
        end else if (en_i) begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    assign last_o   = (dwell_q == DWELL_W'(DWELL_CYCLES - 1));
    assign sample_o = (dwell_q == DWELL_W'(SAMPLE_OFFSET));

endmodule

// File: rtl/tt_stim_sequencer.sv
// Self-timed stimulus sequencer: walks A,B,C through 000..111 and counts
// response mismatches. Optional FIRST_FAIL_CAPTURE_EN adds first-fail capture.
module tt_stim_sequencer
    import tt_stim_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES  = 10,
    parameter int unsigned SAMPLE_OFFSET = 8,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             d_in,
    input  logic             e_in,
    output logic [2:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_flag
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic [2:0]       first_fail,
    output logic             first_fail_vld
`endif
);

    seq_state_e       state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic             tmr_clr, tmr_en, tmr_last, tmr_sample;
    logic [1:0]       exp_resp;
    logic             mismatch;

    tt_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .SAMPLE_OFFSET(SAMPLE_OFFSET)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .last_o  (tmr_last),
        .sample_o(tmr_sample)
    );

    // Case-inequality so an X/Z response is counted as a mismatch
    assign exp_resp = exp_de(vec_q[2], vec_q[1], vec_q[0]);
    assign mismatch = ({d_in, e_in} !== exp_resp);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    tmr_clr = 1'b1;
                end
            end
            RUN: begin
                tmr_en = 1'b1;
                if (tmr_sample && mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ffv_q) begin
                        ff_d  = vec_q;
                        ffv_d = 1'b1;
                    end
                end
                if (tmr_last) begin
                    tmr_clr = 1'b1;
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
        end
    end

    assign {a, b, c} = vec_q;
    assign vec_idx   = vec_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign err_cnt   = err_q;
    assign err_flag  = (err_q != '0);

`ifdef FIRST_FAIL_CAPTURE_EN
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;
`else
    logic unused_ff;
    assign unused_ff = ^{ff_q, ffv_q};
`endif

endmodule

// File: tb/tb_tt_stim_sequencer.sv
// Randomized self-checking bench for tt_stim_sequencer against a vector-level
// reference model; a second instance with ERR_W=2 covers saturation.
`timescale 1ns/1ps
module tb_tt_stim_sequencer;

    localparam int DW = 10;
    localparam int SO = 8;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic       a, b, c, d_in, e_in;
    logic [2:0] vec;
    logic       busy, done, flag;
    logic [3:0] err;
    logic       a2, b2, c2, busy2, done2, flag2;
    logic [2:0] vec2;
    logic [1:0] err2;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [2:0] ff, ff2;
    logic       ffv, ffv2;
`endif

    // Circuit model: per-vector response tables, indexed by the applied vector
    logic [7:0] rd, re, gd, ge;
    assign d_in = rd[{a, b, c}];
    assign e_in = re[{a, b, c}];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tt_stim_sequencer #(.DWELL_CYCLES(DW), .SAMPLE_OFFSET(SO), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
        .d_in(d_in), .e_in(e_in), .vec_idx(vec), .busy(busy), .done(done),
        .err_cnt(err), .err_flag(flag)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .first_fail(ff), .first_fail_vld(ffv)
`endif
    );

    tt_stim_sequencer #(.DWELL_CYCLES(DW), .SAMPLE_OFFSET(SO), .ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2), .c(c2),
        .d_in(d_in), .e_in(e_in), .vec_idx(vec2), .busy(busy2), .done(done2),
        .err_cnt(err2), .err_flag(flag2)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .first_fail(ff2), .first_fail_vld(ffv2)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a vector mismatches if its d or e response differs (X counts)
    function automatic bit vec_bad(input int v, input logic [7:0] tdv, input logic [7:0] tev);
        int ab, ed, ee;
        ab = ((v >> 2) & 1) * ((v >> 1) & 1);
        ee = ab;
        ed = (ab == 0 || (v & 1) == 1) ? 1 : 0;
        return (tdv[v] !== 1'(ed)) || (tev[v] !== 1'(ee));
    endfunction

    function automatic int ref_errs(input logic [7:0] tdv, input logic [7:0] tev);
        int n = 0;
        for (int v = 0; v < 8; v++) if (vec_bad(v, tdv, tev)) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [7:0] tdv, input logic [7:0] tev);
        for (int v = 0; v < 8; v++) if (vec_bad(v, tdv, tev)) return v;
        return -1;
    endfunction

    task automatic run_seq(input string name, input bit glitch);
        int n, e4, e2, fidx, g, ev;
        n    = ref_errs(rd, re);
        fidx = ref_first(rd, re);
        e4   = (n > 15) ? 15 : n;
        e2   = (n > 3) ? 3 : n;
        g    = $urandom_range(1, 79);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 82; k++) begin
            ev = (k <= 8 * DW) ? (k - 1) / DW : 7;
            check_eq($sformatf("%s vec k=%0d", name, k), 32'(vec), 32'(ev));
            check_eq($sformatf("%s abc k=%0d", name, k), 32'({a, b, c}), 32'(ev));
            check_eq($sformatf("%s busy k=%0d", name, k), 32'(busy), 32'(k <= 8 * DW));
            check_eq($sformatf("%s done k=%0d", name, k), 32'(done), 32'(k == 8 * DW + 1));
            if (k == 8 * DW + 1) begin
                check_eq($sformatf("%s done2", name), 32'(done2), 32'd1);
                check_eq($sformatf("%s err_cnt", name), 32'(err), 32'(e4));
                check_eq($sformatf("%s err_flag", name), 32'(flag), 32'(n != 0));
                check_eq($sformatf("%s err_cnt_sat", name), 32'(err2), 32'(e2));
                check_eq($sformatf("%s err_flag_sat", name), 32'(flag2), 32'(n != 0));
`ifdef FIRST_FAIL_CAPTURE_EN
                check_eq($sformatf("%s ff_vld", name), 32'(ffv), 32'(fidx >= 0));
                if (fidx >= 0) check_eq($sformatf("%s ff", name), 32'(ff), 32'(fidx));
`endif
            end
            if (k == 8 * DW + 2) begin
                check_eq($sformatf("%s err_hold", name), 32'(err), 32'(e4));
            end
            start = glitch && (k == g || k == 8 * DW + 1);
            tick();
        end
        start = 1'b0;
        if (fidx < -1) $display("unreachable");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int v = 0; v < 8; v++) begin
            ge[v] = (v >= 6);
            gd[v] = (v != 6);
        end
        rd = gd;
        re = ge;
        repeat (3) tick();
        check_eq("rst abc", 32'({a, b, c}), 32'd0);
        check_eq("rst vec", 32'(vec), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst err", 32'(err), 32'd0);
        check_eq("rst flag", 32'(flag), 32'd0);
        rst_n = 1'b1;
        tick();

        run_seq("correct", 1'b0);
        rd = '0; re = ge;
        run_seq("d0", 1'b0);
        check_eq("d0 count", 32'(err), 32'd7);
        rd = gd; re = '1;
        run_seq("e1", 1'b1);
        check_eq("e1 count", 32'(err), 32'd6);
        rd = gd; re = ge; rd[3] = 1'bx;
        run_seq("xresp", 1'b0);
        for (int r = 0; r < 6; r++) begin
            rd = 8'($urandom);
            re = 8'($urandom);
            run_seq($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
        end

        // Reset mid-run at vector 4
        rd = '0; re = ge;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (45) tick();
        check_eq("abort pre vec", 32'(vec), 32'd4);
        check_eq("abort pre err", 32'(err), 32'd4);
        rst_n = 1'b0;
        tick();
        check_eq("abort abc", 32'({a, b, c}), 32'd0);
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort err", 32'(err), 32'd0);
        check_eq("abort done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 90; k++) begin
            check_eq($sformatf("abort no done k=%0d", k), 32'(done), 32'd0);
            tick();
        end

        // start held across DONE relaunches from IDLE
        start = 1'b1;
        tick();
        repeat (8 * DW) tick();
        check_eq("held done", 32'(done), 32'd1);
        check_eq("held err", 32'(err), 32'd7);
        tick();
        check_eq("held idle busy", 32'(busy), 32'd0);
        check_eq("held idle done", 32'(done), 32'd0);
        tick();
        check_eq("held rerun busy", 32'(busy), 32'd1);
        check_eq("held rerun vec", 32'(vec), 32'd0);
        check_eq("held rerun err", 32'(err), 32'd0);
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
